// File: rtl/bank_row_loader.sv
// bank_row_loader: fill stage for the M10K bank array.
// It accepts a row-major matrix as a valid/ready stream of W-bit elements.
// It packs N_BANKS consecutive elements into one word and writes that word
// to every bank at once through port A. Element k of a row lands in bank
// (k mod N_BANKS).
module bank_row_loader #(
    parameter int N_BANKS        = 16,
    parameter int W              = 8,
    parameter int DEPTH_PER_BANK = 1024,
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    localparam int AW            = (DEPTH_PER_BANK > 1) ? $clog2(DEPTH_PER_BANK) : 1,
    localparam int BEW           = (W / 8 > 1) ? W / 8 : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    output logic                    busy,
    output logic                    done,
    input  logic                    s_valid,
    input  logic [W-1:0]            s_data,
    output logic                    s_ready,
    output logic [N_BANKS-1:0]      a_en,
    output logic [N_BANKS-1:0]      a_we,
    output logic [N_BANKS*AW-1:0]   a_addr,
    output logic [N_BANKS*W-1:0]    a_din,
    output logic [N_BANKS*BEW-1:0]  a_be
);

    localparam int TOTAL_WORDS = ROWS * COLS / N_BANKS;
    localparam int LW          = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int WCW         = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;

    // A packed word must never straddle two matrix rows.
    generate
        if (COLS % N_BANKS != 0) begin : g_bad_cols
            $error("bank_row_loader: COLS must be a multiple of N_BANKS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [LW-1:0]        lane_q;      // next lane to fill
    logic [WCW-1:0]       word_q;      // words written in this load
    logic [AW-1:0]        addr_q;      // base + word, wrapped to the bank depth
    logic                 wr_q;        // write strobe for the current cycle
    logic [N_BANKS*AW-1:0] a_addr_q;
    logic [N_BANKS*W-1:0]  a_din_q;
    logic [W-1:0]         lane_mem [N_BANKS];
    logic [N_BANKS*W-1:0] din_next;

    logic                 accept;
    logic                 last_lane;
    logic                 last_word;

    assign accept    = s_valid && s_ready;
    assign last_lane = (lane_q == LW'(N_BANKS - 1));
    assign last_word = (word_q == WCW'(TOTAL_WORDS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every clocked state update uses <=, so all registers in a
        // cycle see the values from before the edge, whatever the statement order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the load ends on the final element, DONE lasts one cycle.
    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // state_d, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: if (accept && last_lane && last_word) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status and handshake outputs, decoded from the state alone.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                busy    = 1'b1;
                s_ready = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Packed word: the stored lanes plus the element being accepted on the last lane.
    always_comb begin
        din_next = '0;
        for (int i = 0; i < N_BANKS - 1; i++) begin
            din_next[i*W +: W] = lane_mem[i];
        end
        din_next[(N_BANKS-1)*W +: W] = s_data;
    end

    // Lane, word and address tracking, plus the registered port A write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q   <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            a_addr_q <= '0;
            a_din_q  <= '0;
        end else begin
            wr_q <= 1'b0;
            if (state_q == S_IDLE && start) begin
                addr_q <= base_addr;
                word_q <= '0;
            end
            if (accept) begin
                lane_q <= last_lane ? '0 : lane_q + 1'b1;
                if (last_lane) begin
                    wr_q     <= 1'b1;
                    a_addr_q <= {N_BANKS{addr_q}};
                    a_din_q  <= din_next;
                    word_q   <= last_word ? '0 : word_q + 1'b1;
                    addr_q   <= (addr_q == AW'(DEPTH_PER_BANK - 1)) ? '0 : addr_q + 1'b1;
                end
            end
        end
    end

    // Lane storage for the word being assembled.
    always_ff @(posedge clk) begin
        // NOTE: the lane storage has no reset; each lane is written before it
        // is read, and the control path alone decides when a word goes out.
        if (accept) begin
            lane_mem[lane_q] <= s_data;
        end
    end

    assign a_en   = {N_BANKS{wr_q}};
    assign a_we   = {N_BANKS{wr_q}};
    assign a_addr = a_addr_q;
    assign a_din  = a_din_q;
    assign a_be   = '1;

endmodule

// File: tb/tb_bank_row_loader.sv
// tb_bank_row_loader: directed bench for bank_row_loader with default parameters.
// A negedge monitor logs every port A write and checks strobe timing against
// lane-15 accepts. Each test compares the logged writes with hand-computed values.
module tb_bank_row_loader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic         busy;
    logic         done;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic [15:0]  a_en;
    logic [15:0]  a_we;
    logic [159:0] a_addr;
    logic [127:0] a_din;
    logic [15:0]  a_be;

    int n_checks = 0;
    int n_fail   = 0;

    logic [159:0] log_addr[$];
    logic [127:0] log_din[$];
    logic         log_done[$];
    int           done_cnt = 0;

    int           lane_seen = 0;
    bit           expect_wr = 0;

    bank_row_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .a_en      (a_en),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_din     (a_din),
        .a_be      (a_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: a write must follow a lane-15 accept by exactly one cycle.
    always @(negedge clk) begin
        if (rst) begin
            lane_seen = 0;
            expect_wr = 0;
        end else begin
            check("strobe_en", a_en, expect_wr ? 16'hFFFF : 16'h0000);
            check("strobe_we", a_we, expect_wr ? 16'hFFFF : 16'h0000);
            if (a_en != 16'h0000) begin
                log_addr.push_back(a_addr);
                log_din.push_back(a_din);
                log_done.push_back(done);
            end
            if (done) begin
                done_cnt++;
                check("done_state_busy_ready", {busy, s_ready}, 2'b10);
            end
            expect_wr = s_valid && s_ready && (lane_seen == 15);
            if (s_valid && s_ready) lane_seen = (lane_seen + 1) % 16;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
        log_done.delete();
        done_cnt = 0;
    endtask

    // Start a load and stream n elements of value (off + k); gap is the
    // percentage of cycles with s_valid low. hold_start keeps start high
    // through LOAD and the DONE cycle.
    task automatic stream(input int n, input int gap, input int off, input bit hold_start,
                          input logic [9:0] base);
        int  k;
        int  cyc;
        bit  acc;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = hold_start;
        k   = 0;
        cyc = 0;
        if ($urandom_range(0, 99) < gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end else begin
            s_valid = 1'b1;
            s_data  = 8'(off + k);
        end
        while (k < n && cyc < 2000) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
            if (k < n) begin
                if ($urandom_range(0, 99) < gap) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                end else begin
                    s_valid = 1'b1;
                    s_data  = 8'(off + k);
                end
            end else begin
                s_valid = 1'b0;
            end
        end
        if (cyc >= 2000) check("stream_timeout", k, n);
        if (hold_start) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 50);
        check("idle_timeout", busy, 1'b0);
    endtask

    // Word j: every lane address is (base + j) mod 1024; lane i holds off + 16j + i.
    task automatic check_writes(input int n_words, input int base, input int off, input bit exp_done);
        logic [9:0]   ea;
        logic [127:0] ed;
        int           m;
        check("n_writes", log_addr.size(), n_words);
        m = (log_addr.size() < n_words) ? log_addr.size() : n_words;
        for (int j = 0; j < m; j++) begin
            ea = 10'((base + j) % 1024);
            for (int i = 0; i < 16; i++) ed[i*8 +: 8] = 8'(off + 16 * j + i);
            check($sformatf("wr_addr[%0d]", j), log_addr[j], {16{ea}});
            check($sformatf("wr_din[%0d]", j), log_din[j], ed);
            check($sformatf("wr_done[%0d]", j), log_done[j], exp_done && (j == n_words - 1));
        end
        check("done_count", done_cnt, exp_done ? 1 : 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = '0;

        // 1: reset held with random inputs, all outputs stay zero.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start     = 1'($urandom);
            s_valid   = 1'($urandom);
            s_data    = 8'($urandom);
            base_addr = 10'($urandom);
            @(negedge clk);
            check("rst_ctrl", {busy, done, s_ready, a_en, a_we}, '0);
            check("rst_addr", a_addr, '0);
            check("rst_din", a_din, '0);
        end
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, done, s_ready}, 3'b000);
        check("a_be", a_be, 16'hFFFF);

        // 2: base 0, elements 0..255 with no gaps.
        clear_log();
        stream(256, 0, 0, 1'b0, 10'd0);
        wait_idle();
        check_writes(16, 0, 0, 1'b1);

        // 3: same stream with s_valid low about 40% of cycles.
        clear_log();
        stream(256, 40, 0, 1'b0, 10'd0);
        wait_idle();
        check_writes(16, 0, 0, 1'b1);

        // 4: address wrap from base 1020.
        clear_log();
        stream(256, 0, 0, 1'b0, 10'd1020);
        wait_idle();
        check_writes(16, 1020, 0, 1'b1);

        // 5: start held through LOAD and DONE, then s_valid driven in IDLE.
        clear_log();
        stream(256, 0, 0, 1'b1, 10'd5);
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = 8'hAA;
            @(negedge clk);
            check("idle_no_ready", {busy, s_ready}, 2'b00);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        check_writes(16, 5, 0, 1'b1);

        // 6: reset after 5 words plus 7 elements, then a clean reload.
        clear_log();
        stream(87, 0, 0, 1'b0, 10'd0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        rst     = 1'b1;
        #1;
        check("midrst_ctrl", {busy, done, s_ready, a_en, a_we}, '0);
        check("midrst_addr", a_addr, '0);
        check("midrst_din", a_din, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check_writes(5, 0, 0, 1'b0);
        clear_log();
        stream(256, 0, 100, 1'b0, 10'd0);
        wait_idle();
        check_writes(16, 0, 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
